mmio_io_hub: RTL and testbench
==============================

MMIO_IO_HUB -- requirements
Module: mmio_io_hub

Interface
REQ-001 Parameter IN_W, 16: width of each input port.
REQ-002 Parameter NUM_IN, 2: number of input ports; legal range 1..8.
REQ-003 Parameter OUT_W, 16: width of each output port.
REQ-004 Parameter NUM_OUT, 4: number of output registers; legal range 1..8.
REQ-005 Parameter BASE_AD, 32'h11000000: base of the block's address window.
REQ-006 Parameter STRIDE, 32'h20: spacing between port addresses.
REQ-007 CLK  input  1: single clock; all state changes on its rising edge.
REQ-008 RST  input  1: asynchronous, active-high reset.
REQ-009 IOBUS_ADDR  input  32: CPU bus address.
REQ-010 IOBUS_OUT  input  32: CPU write data.
REQ-011 IOBUS_WR  input  1: CPU write strobe, sampled on CLK rising edge.
REQ-012 IOBUS_IN  output  32: read data returned to the CPU.
REQ-013 IN_PORTS  input  NUM_IN*IN_W: asynchronous board inputs; port i occupies bits [i*IN_W +: IN_W].
REQ-014 OUT_PORTS  output  NUM_OUT*OUT_W: registered board outputs; port j occupies bits [j*OUT_W +: OUT_W].
REQ-015 INTR  output  1: level interrupt request to the CPU.

Function
REQ-016 Address map SHALL be: input i at BASE_AD+i*STRIDE; output j at BASE_AD+(NUM_IN+j)*STRIDE; INTR_PEND at BASE_AD+0x400; INTR_EN at BASE_AD+0x420.
REQ-017 Decode SHALL require an exact 32-bit address match; every other address is unmapped.
REQ-018 Each input port SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-019 Reads SHALL be combinational with zero latency: input i returns zero-extended s2; output j returns its register value zero-extended; INTR_PEND/INTR_EN return their bits in [NUM_IN-1:0] with upper bits zero; unmapped addresses return 32'h0.
REQ-020 A write to output j with IOBUS_WR=1 SHALL load IOBUS_OUT[OUT_W-1:0] into that register on the same rising edge; OUT_PORTS reflects it immediately after that edge.
REQ-021 Writes to input-port addresses or unmapped addresses SHALL be ignored with no state change.
REQ-022 A change-detect register prev_i SHALL load s2_i every cycle; pending bit i SHALL be set on an edge where s2_i != prev_i.
REQ-023 Latency: an IN_PORTS change stable before edge k appears in readback after edge k+1 and sets pending after edge k+2.
REQ-024 A write to INTR_PEND SHALL clear each pending bit whose IOBUS_OUT bit is 1 (write-1-to-clear); 0 bits are unaffected.
REQ-025 If a set and a W1C clear hit the same pending bit on the same edge, set SHALL win.
REQ-026 A write to INTR_EN SHALL load IOBUS_OUT[NUM_IN-1:0].
REQ-027 INTR SHALL equal |(INTR_PEND & INTR_EN), derived from registers only.
REQ-028 Output-register values SHALL persist indefinitely until rewritten or reset.

Reset
REQ-029 While RST=1, immediately and asynchronously: s1, s2, prev, all output registers, INTR_PEND and INTR_EN SHALL be 0, so OUT_PORTS=0 and INTR=0.
REQ-030 On RST release, no pending bit SHALL be set unless an input has changed relative to 0 after release.
REQ-031 RST asserted mid-write SHALL override the write; the register reads 0 afterward.

Verification
REQ-032 Write 32'hABCD1234 to BASE+0x40 (output 0 at defaults) -> OUT_PORTS[15:0]=16'h1234 after that edge; read of BASE+0x40 returns 32'h00001234.
REQ-033 IN_PORTS[15:0] steps from 0 to 16'h00F0 -> read of BASE+0x00 returns 32'h000000F0 two edges later; INTR_PEND reads 32'h1 after the third edge.
REQ-034 INTR_EN=1 with pending bit 0 set -> INTR=1; write 32'h1 to BASE+0x400 -> INTR=0 next cycle; write 32'h0 instead -> INTR stays 1.
REQ-035 Input 1 change timed so pending set coincides with a W1C of bit 1 -> bit 1 remains 1.
REQ-036 Write to BASE+0x20 and to 32'h11000004 -> no state change; reads of unmapped addresses return 0.
REQ-037 Assert RST asynchronously between edges after outputs and enables are set -> OUT_PORTS and INTR drop to 0 without a clock edge; all reads return 0 after release.

Source files
------------

// File: rtl/mmio_io_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mmio_io_hub                                                           |
// | Memory-mapped board I/O: synchronized inputs, output registers and a  |
// | change-detect interrupt with W1C pending / enable registers.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mmio_io_hub #(
  parameter int          IN_W    = 16,
  parameter int          NUM_IN  = 2,
  parameter int          OUT_W   = 16,
  parameter int          NUM_OUT = 4,
  parameter logic [31:0] BASE_AD = 32'h11000000,
  parameter logic [31:0] STRIDE  = 32'h20
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [31:0]              IOBUS_ADDR,
  input  logic [31:0]              IOBUS_OUT,
  input  logic                     IOBUS_WR,
  output logic [31:0]              IOBUS_IN,
  input  logic [NUM_IN*IN_W-1:0]   IN_PORTS,
  output logic [NUM_OUT*OUT_W-1:0] OUT_PORTS,
  output logic                     INTR
);

  localparam logic [31:0] c_PEND_ADDR = BASE_AD + 32'h400;
  localparam logic [31:0] c_EN_ADDR   = BASE_AD + 32'h420;

  logic [NUM_IN*IN_W-1:0] r_s1;
  logic [NUM_IN*IN_W-1:0] r_s2;
  logic [NUM_IN*IN_W-1:0] r_prev;
  logic [NUM_IN-1:0]      r_pend;
  logic [NUM_IN-1:0]      r_en;
  logic [OUT_W-1:0]       r_out [NUM_OUT];

  logic [NUM_IN-1:0]      w_set;
  logic [NUM_IN-1:0]      w_clr;
  logic                   w_pend_hit;
  logic                   w_en_hit;
  logic [31:0]            w_in_rd  [NUM_IN];
  logic [31:0]            w_out_rd [NUM_OUT];
  logic [31:0]            w_pend_ext;
  logic [31:0]            w_en_ext;
  logic [31:0]            w_rdata;
  logic                   w_unused_wdata;

  assign w_unused_wdata = ^IOBUS_OUT;
  assign w_pend_hit     = (IOBUS_ADDR == c_PEND_ADDR);
  assign w_en_hit       = (IOBUS_ADDR == c_EN_ADDR);
  assign w_clr          = (IOBUS_WR && w_pend_hit) ? IOBUS_OUT[NUM_IN-1:0] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_pend <= '0;
      r_en   <= '0;
    end else begin
      r_s1   <= IN_PORTS;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      // a fresh change outranks a simultaneous W1C so no edge is lost
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (IOBUS_WR && w_en_hit) begin
        r_en <= IOBUS_OUT[NUM_IN-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      localparam logic [31:0] c_IN_ADDR = BASE_AD + STRIDE * 32'(gi);
      logic [31:0] w_ext;

      always_comb begin
        w_ext             = '0;
        w_ext[IN_W-1:0]   = r_s2[gi*IN_W +: IN_W];
      end

      assign w_set[gi]   = (r_s2[gi*IN_W +: IN_W] != r_prev[gi*IN_W +: IN_W]);
      assign w_in_rd[gi] = (IOBUS_ADDR == c_IN_ADDR) ? w_ext : 32'h0;
    end

    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      localparam logic [31:0] c_OUT_ADDR = BASE_AD + STRIDE * 32'(NUM_IN + gi);
      logic        w_hit;
      logic [31:0] w_ext;

      assign w_hit = (IOBUS_ADDR == c_OUT_ADDR);

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_out[gi] <= '0;
        end else if (IOBUS_WR && w_hit) begin
          r_out[gi] <= IOBUS_OUT[OUT_W-1:0];
        end
      end

      always_comb begin
        w_ext            = '0;
        w_ext[OUT_W-1:0] = r_out[gi];
      end

      assign w_out_rd[gi]                 = w_hit ? w_ext : 32'h0;
      assign OUT_PORTS[gi*OUT_W +: OUT_W] = r_out[gi];
    end
  endgenerate

  always_comb begin
    w_pend_ext               = '0;
    w_pend_ext[NUM_IN-1:0]   = r_pend;
    w_en_ext                 = '0;
    w_en_ext[NUM_IN-1:0]     = r_en;
  end

  // at most one source matches a given address, so an OR-tree is a mux
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_rdata = w_rdata | w_in_rd[i];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      w_rdata = w_rdata | w_out_rd[j];
    end
    if (w_pend_hit) begin
      w_rdata = w_rdata | w_pend_ext;
    end
    if (w_en_hit) begin
      w_rdata = w_rdata | w_en_ext;
    end
  end

  assign IOBUS_IN = w_rdata;
  assign INTR     = |(r_pend & r_en);

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mmio_io_hub                                                        |
// | Directed bench for mmio_io_hub at default parameters.                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mmio_io_hub;

  localparam logic [31:0] c_BASE = 32'h11000000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT  = '0;
  logic        IOBUS_WR   = 1'b0;
  logic [31:0] IOBUS_IN;
  logic [31:0] IN_PORTS   = '0;
  logic [63:0] OUT_PORTS;
  logic        INTR;

  int n_vec = 0;
  int n_err = 0;

  mmio_io_hub dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .IN_PORTS   (IN_PORTS),
    .OUT_PORTS  (OUT_PORTS),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    IOBUS_ADDR = addr;
    #1;
    check(tag, {32'h0, IOBUS_IN}, {32'h0, exp});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR   = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_out", OUT_PORTS, 64'h0);
    check("rst_intr", {63'h0, INTR}, 64'h0);
    rd("rst_rd_out0", c_BASE + 32'h40, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    wr(c_BASE + 32'h40, 32'hABCD1234);
    check("out0_port", OUT_PORTS, 64'h0000_0000_0000_1234);
    rd("out0_rd", c_BASE + 32'h40, 32'h00001234);
    wr(c_BASE + 32'hA0, 32'h00005555);
    check("out3_port", OUT_PORTS, 64'h5555_0000_0000_1234);
    rd("out3_rd", c_BASE + 32'hA0, 32'h00005555);

    // input 0 steps to 0x00F0 ahead of edge k
    @(negedge CLK);
    IN_PORTS[15:0] = 16'h00F0;
    @(posedge CLK); #1;
    rd("in0_after_k", c_BASE, 32'h0);
    @(posedge CLK); #1;
    rd("in0_after_k1", c_BASE, 32'h000000F0);
    rd("pend_after_k1", c_BASE + 32'h400, 32'h0);
    @(posedge CLK); #1;
    rd("pend_after_k2", c_BASE + 32'h400, 32'h1);
    check("intr_no_en", {63'h0, INTR}, 64'h0);

    wr(c_BASE + 32'h420, 32'h1);
    check("intr_en", {63'h0, INTR}, 64'h1);
    rd("en_rd", c_BASE + 32'h420, 32'h1);
    wr(c_BASE + 32'h400, 32'h0);
    check("intr_w0", {63'h0, INTR}, 64'h1);
    wr(c_BASE + 32'h400, 32'h1);
    check("intr_w1c", {63'h0, INTR}, 64'h0);
    rd("pend_cleared", c_BASE + 32'h400, 32'h0);

    // input 1 change lands its pending set on the same edge as a W1C of bit 1
    @(negedge CLK);
    IN_PORTS[31:16] = 16'h0003;
    @(posedge CLK);
    @(posedge CLK);
    wr(c_BASE + 32'h400, 32'h2);
    rd("set_wins", c_BASE + 32'h400, 32'h2);
    wr(c_BASE + 32'h400, 32'h2);
    rd("pend1_clear", c_BASE + 32'h400, 32'h0);

    wr(c_BASE + 32'h20, 32'h0000FFFF);
    wr(32'h11000004, 32'hFFFFFFFF);
    check("unmapped_out", OUT_PORTS, 64'h5555_0000_0000_1234);
    rd("unmapped_pend", c_BASE + 32'h400, 32'h0);
    rd("unmapped_en", c_BASE + 32'h420, 32'h1);
    rd("in1_rd", c_BASE + 32'h20, 32'h00000003);
    rd("rd_unmapped_a", 32'h11000004, 32'h0);
    rd("rd_unmapped_b", c_BASE + 32'h440, 32'h0);

    // raise pending bit 0 so INTR is high before the asynchronous reset
    @(negedge CLK);
    IN_PORTS[15:0] = 16'h00F1;
    repeat (3) @(posedge CLK);
    #1;
    check("intr_pre_rst", {63'h0, INTR}, 64'h1);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_out", OUT_PORTS, 64'h0);
    check("async_rst_intr", {63'h0, INTR}, 64'h0);
    IN_PORTS   = '0;
    IOBUS_ADDR = c_BASE + 32'h60;
    IOBUS_OUT  = 32'h00007777;
    IOBUS_WR   = 1'b1;
    @(posedge CLK); #1;
    IOBUS_WR   = 1'b0;
    check("rst_over_wr", OUT_PORTS, 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    rd("post_out0", c_BASE + 32'h40, 32'h0);
    rd("post_out1", c_BASE + 32'h60, 32'h0);
    rd("post_out3", c_BASE + 32'hA0, 32'h0);
    rd("post_in0", c_BASE, 32'h0);
    rd("post_pend", c_BASE + 32'h400, 32'h0);
    rd("post_en", c_BASE + 32'h420, 32'h0);
    check("post_intr", {63'h0, INTR}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
